// File: rtl/function_plotter_if.sv
// Pixel write channel from the plotter to the VGA adapter (valid/ready).
interface function_plotter_if;
    logic       plot;
    logic       plot_ready;
    logic [7:0] plot_x;
    logic [7:0] plot_y;
    logic [2:0] plot_colour;

    modport master (output plot, plot_x, plot_y, plot_colour, input plot_ready);
    modport slave  (input plot, plot_x, plot_y, plot_colour, output plot_ready);
endinterface

// File: rtl/function_plotter.sv
// Sweeps x across the plot range, samples the generator's row for each column and
// emits pixel writes, filling vertically between consecutive in-bounds samples.
module function_plotter #(
    parameter int X_MIN         = -80,
    parameter int X_MAX         = 79,
    parameter int SETTLE_CYCLES = 2,
    parameter int CONNECT       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         degree,
    input  logic [2:0]         colour_in,
    input  logic [7:0]         y_in,
    input  logic               oob_in,
    output logic signed [7:0]  x_val,
    output logic [2:0]         calculate,
    output logic               busy,
    output logic               done,
    function_plotter_if.master pix
);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DRAW, NEXT, DONE} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic signed [7:0] X_FIRST = 8'(X_MIN);
    localparam logic signed [7:0] X_LAST  = 8'(X_MAX);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic [7:0]       row;
    logic [7:0]       row_hi;
    logic [7:0]       cur_y;
    logic [7:0]       prev_y;
    logic             prev_valid;
    logic [2:0]       colour;
    logic [7:0]       samp_lo;
    logic [7:0]       samp_hi;
    logic             accept;

    assign pix.plot        = (state == DRAW);
    assign pix.plot_x      = x_val - X_FIRST;
    assign pix.plot_y      = row;
    assign pix.plot_colour = colour;
    assign done            = (state == DONE);
    assign accept          = pix.plot && pix.plot_ready;

    // Span of rows for this column: from the previous sample to the new one when connecting.
    always_comb begin
        samp_lo = y_in;
        samp_hi = y_in;
        if (CONNECT != 0 && prev_valid) begin
            if (prev_y < y_in) samp_lo = prev_y;
            else               samp_hi = prev_y;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  state_next = oob_in ? NEXT : DRAW;
            DRAW:    if (accept && row == row_hi) state_next = NEXT;
            NEXT:    state_next = (x_val == X_LAST) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath; every field stays put while a pixel is stalled by the adapter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_val      <= X_FIRST;
            calculate  <= '0;
            colour     <= '0;
            busy       <= 1'b0;
            settle_cnt <= '0;
            row        <= '0;
            row_hi     <= '0;
            cur_y      <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        calculate  <= degree;
                        colour     <= colour_in;
                        x_val      <= X_FIRST;
                        prev_valid <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                SAMPLE: begin
                    cur_y <= y_in;
                    if (oob_in) begin
                        prev_valid <= 1'b0;
                    end else begin
                        row    <= samp_lo;
                        row_hi <= samp_hi;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        if (row == row_hi) begin
                            prev_y     <= cur_y;
                            prev_valid <= 1'b1;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end
                end
                NEXT: begin
                    if (x_val != X_LAST) begin
                        x_val      <= x_val + 8'sd1;
                        settle_cnt <= '0;
                    end
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_function_plotter.sv
// Self-checking bench for function_plotter: a generator model drives y/oob from x_val,
// a scoreboard holds the expected pixel stream of each sweep.
module tb_function_plotter;

    typedef struct {
        logic [7:0] col;
        logic [7:0] row;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int         mode;
        logic [2:0] deg;
        logic [2:0] colour;
        int         exp_plots;
        bit         stall;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        degree;
    logic [2:0]        colour_in;
    logic [7:0]        y_in;
    logic              oob_in;
    logic signed [7:0] x_val;
    logic [2:0]        calculate;
    logic              busy;
    logic              done;
    logic              ready_drv = 1'b1;

    int checks = 0;
    int failures = 0;
    int sweep_mode = 0;
    int accepted = 0;
    int done_count = 0;
    int stall_left = 0;
    bit stall_req = 1'b0;
    bit stall_done = 1'b0;
    int age = 0;
    logic signed [7:0] last_x = 8'sd0;
    logic last_busy = 1'b0;
    pix_t exp_q[$];
    vec_t vecs[5];

    function_plotter_if pif ();
    assign pif.plot_ready = ready_drv;

    function_plotter #(.SETTLE_CYCLES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .degree    (degree),
        .colour_in (colour_in),
        .y_in      (y_in),
        .oob_in    (oob_in),
        .x_val     (x_val),
        .calculate (calculate),
        .busy      (busy),
        .done      (done),
        .pix       (pif)
    );

    always #5 clk = ~clk;

    // Settled generator row per mode: flat, descending line, line with an off-screen start.
    function automatic logic [7:0] gen_y(int mode, int x);
        if (mode == 0) return 8'd120;
        if (mode == 3) return 8'd50;
        return 8'(120 - x);
    endfunction

    function automatic logic gen_oob(int mode, int x);
        return (mode == 2) && (x <= -71);
    endfunction

    // Mode 3 only shows the real row during the last settle cycle and the sample cycle.
    always_comb begin
        y_in   = gen_y(sweep_mode, int'(x_val));
        oob_in = gen_oob(sweep_mode, int'(x_val));
        if (sweep_mode == 3) y_in = (age < 2) ? 8'd10 : ((age < 4) ? 8'd50 : 8'd200);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (x_val != last_x || (busy && !last_busy)) age = 0;
            else age = age + 1;
            last_x    = x_val;
            last_busy = busy;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_expected(input int mode, input logic [2:0] col);
        bit pv = 1'b0;
        int py = 0;
        int cy, lo, hi;
        exp_q.delete();
        for (int x = -80; x <= 79; x++) begin
            if (gen_oob(mode, x)) begin
                pv = 1'b0;
            end else begin
                cy = int'(gen_y(mode, x));
                lo = cy;
                hi = cy;
                if (pv) begin
                    lo = (py < cy) ? py : cy;
                    hi = (py < cy) ? cy : py;
                end
                for (int r = lo; r <= hi; r++) exp_q.push_back('{col: 8'(x + 80), row: 8'(r), c: col});
                py = cy;
                pv = 1'b1;
            end
        end
    endtask

    // Pixel monitor and adapter back-pressure, evaluated away from the rising edge.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (stall_left > 0) begin
                    if (exp_q.size() > 0)
                        check_output("stall_hold", {pif.plot, pif.plot_x, pif.plot_y, x_val},
                                     {1'b1, exp_q[0].col, exp_q[0].row, 8'(exp_q[0].col - 8'd80)});
                    stall_left--;
                    if (stall_left == 0) ready_drv = 1'b1;
                end else if (stall_req && !stall_done && accepted == 2 && pif.plot) begin
                    ready_drv  = 1'b0;
                    stall_left = 5;
                    stall_done = 1'b1;
                end
                if (pif.plot && ready_drv) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_pixel", {16'h0, pif.plot_x, pif.plot_y}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("pixel", {pif.plot_x, pif.plot_y, pif.plot_colour}, {e.col, e.row, e.c});
                    end
                    accepted++;
                end
                if (done) done_count++;
            end
        end
    end

    task automatic apply_stimulus(input logic [2:0] deg, input logic [2:0] col);
        @(negedge clk);
        degree    = deg;
        colour_in = col;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        degree    = ~deg;
        colour_in = ~col;
    endtask

    task automatic wait_x(input logic signed [7:0] target);
        int budget = 0;
        while (x_val != target && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        check_output("wait_x_reached", {24'h0, $unsigned(x_val)}, {24'h0, $unsigned(target)});
    endtask

    task automatic run_sweep(input vec_t v);
        int budget = 0;
        sweep_mode = v.mode;
        build_expected(v.mode, v.colour);
        accepted   = 0;
        done_count = 0;
        stall_req  = v.stall;
        stall_done = 1'b0;
        apply_stimulus(v.deg, v.colour);
        repeat (40) @(negedge clk);
        check_output("calculate_mid", calculate, v.deg);
        check_output("busy_mid", busy, 1);
        while (done_count == 0 && budget < 6000) begin
            @(negedge clk);
            budget++;
        end
        check_output("done_seen", done_count != 0, 1);
        repeat (3) @(negedge clk);
        check_output("busy_done_after", {busy, done}, 0);
        check_output("done_pulses", done_count, 1);
        check_output("plot_count", accepted, v.exp_plots);
        check_output("queue_left", exp_q.size(), 0);
        check_output("calculate_end", calculate, v.deg);
    endtask

    initial begin
        int budget;
        vecs[0] = '{mode: 0, deg: 3'd0, colour: 3'b010, exp_plots: 160, stall: 1'b0};
        vecs[1] = '{mode: 1, deg: 3'd3, colour: 3'b101, exp_plots: 319, stall: 1'b0};
        vecs[2] = '{mode: 2, deg: 3'd5, colour: 3'b111, exp_plots: 299, stall: 1'b0};
        vecs[3] = '{mode: 1, deg: 3'd1, colour: 3'b011, exp_plots: 319, stall: 1'b1};
        vecs[4] = '{mode: 3, deg: 3'd7, colour: 3'b100, exp_plots: 160, stall: 1'b0};

        reset = 1'b0;
        start = 1'b0;
        degree = 3'd0;
        colour_in = 3'd0;
        #12;
        check_output("reset_x_val", {24'h0, $unsigned(x_val)}, 32'hB0);
        check_output("reset_calculate", calculate, 0);
        check_output("reset_pixel_bus", {pif.plot, pif.plot_x, pif.plot_y, pif.plot_colour}, 0);
        check_output("reset_busy_done", {busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] sweep vector %0d mode %0d", i, vecs[i].mode);
            run_sweep(vecs[i]);
        end

        // Restart attempt mid-sweep, then asynchronous reset while a pixel is presented.
        $display("[TB] restart and mid-sweep reset");
        sweep_mode = 1;
        build_expected(1, 3'b001);
        accepted   = 0;
        done_count = 0;
        stall_req  = 1'b0;
        apply_stimulus(3'd4, 3'b001);
        wait_x(-8'sd40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_x(8'sd0);
        budget = 0;
        while (!pif.plot && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        check_output("plot_before_reset", {pif.plot, busy}, 2'b11);
        #1;
        reset = 1'b0;
        #1;
        check_output("reset_async_drop", {pif.plot, busy, done, $unsigned(x_val)}, {3'b000, 8'hB0});
        check_output("reset_async_bus", {pif.plot_x, pif.plot_y, pif.plot_colour}, 0);
        @(negedge clk);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("no_done_after_reset", done_count, 0);
        check_output("idle_after_reset", busy, 0);
        run_sweep('{mode: 0, deg: 3'd2, colour: 3'b110, exp_plots: 160, stall: 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
